// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/MEM requester handshakes, the memory-side port and the stall outputs.
// slave is the arbiter's view; master is the pipeline/memory environment.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W-1:0] instr_rdata;
    logic              instr_ack;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  instr_req, instr_addr, data_req, data_we, data_addr, data_wdata,
        input  mem_rdata, mem_ready,
        output instr_rdata, instr_ack, data_rdata, data_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output instr_req, instr_addr, data_req, data_we, data_addr, data_wdata,
        output mem_rdata, mem_ready,
        input  instr_rdata, instr_ack, data_rdata, data_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency single-port memory between instruction fetch and load/store.
// Data wins ties unless it won the previous grant, so IF cannot be starved.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
    typedef enum logic {INSTR, DATA} grant_t;

    state_t            state;
    grant_t            last_grant;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              instr_ack;
    logic              data_ack;
    logic [DATA_W-1:0] instr_rdata;
    logic [DATA_W-1:0] data_rdata;

    // A requester whose ack is showing this cycle is finishing, not asking again.
    logic instr_elig;
    logic data_elig;
    assign instr_elig = bus.instr_req & ~instr_ack;
    assign data_elig  = bus.data_req  & ~data_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= INSTR;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr_ack   <= 1'b0;
            data_ack    <= 1'b0;
            instr_rdata <= '0;
            data_rdata  <= '0;
        end else begin
            instr_ack <= 1'b0;
            data_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_elig && !(instr_elig && last_grant == DATA)) begin
                        state      <= DBUSY;
                        last_grant <= DATA;
                        mem_req    <= 1'b1;
                        mem_we     <= bus.data_we;
                        mem_addr   <= bus.data_addr;
                        mem_wdata  <= bus.data_wdata;
                    end else if (instr_elig) begin
                        state      <= IBUSY;
                        last_grant <= INSTR;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= bus.instr_addr;
                    end
                end
                IBUSY: begin
                    if (bus.mem_ready) begin
                        state       <= IDLE;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        instr_ack   <= 1'b1;
                        instr_rdata <= bus.mem_rdata;
                    end
                end
                DBUSY: begin
                    if (bus.mem_ready) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        data_ack   <= 1'b1;
                        data_rdata <= bus.mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.instr_ack   = instr_ack;
    assign bus.data_ack    = data_ack;
    assign bus.instr_rdata = instr_rdata;
    assign bus.data_rdata  = data_rdata;
    assign bus.stall_if    = bus.instr_req & ~instr_ack;
    assign bus.stall_mem   = bus.data_req & ~data_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic, checked cycle by cycle against a
// transaction-level model of the arbiter and a word-addressed memory image.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit [31:0] memArr [bit [31:0]];

    // Model: who owns the memory (0 none, 1 fetch, 2 data) and what the pins should show.
    int          owner;
    bit          lastWasData;
    logic        expMemReq, expWe, expIAck, expDAck;
    logic [31:0] expAddr, expWdata, expIRdata, expDRdata;
    bit          dataIsLoad;
    logic [31:0] dataAddr;

    bit          iActive, dActive, dWeR;
    logic [31:0] iAddrR, dAddrR, dWdataR;

    function automatic bit [31:0] memRead(input bit [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        owner       = 0;
        lastWasData = 1'b0;
        expMemReq   = 1'b0;
        expWe       = 1'b0;
        expIAck     = 1'b0;
        expDAck     = 1'b0;
        expAddr     = '0;
        expWdata    = '0;
        expIRdata   = '0;
        expDRdata   = '0;
        dataIsLoad  = 1'b0;
        dataAddr    = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit iWants, dWants, nIAck, nDAck;
        nIAck  = 1'b0;
        nDAck  = 1'b0;
        iWants = bus.instr_req && !expIAck;
        dWants = bus.data_req && !expDAck;
        if (owner != 0) begin
            if (bus.mem_ready) begin
                if (owner == 1) begin
                    nIAck     = 1'b1;
                    expIRdata = bus.mem_rdata;
                end else begin
                    nDAck     = 1'b1;
                    expDRdata = bus.mem_rdata;
                    if (expWe) memArr[expAddr] = expWdata;
                end
                owner     = 0;
                expMemReq = 1'b0;
                expWe     = 1'b0;
            end
        end else if (dWants && !(iWants && lastWasData)) begin
            owner       = 2;
            lastWasData = 1'b1;
            expMemReq   = 1'b1;
            expWe       = bus.data_we;
            expAddr     = bus.data_addr;
            expWdata    = bus.data_wdata;
            dataIsLoad  = !bus.data_we;
            dataAddr    = bus.data_addr;
        end else if (iWants) begin
            owner       = 1;
            lastWasData = 1'b0;
            expMemReq   = 1'b1;
            expWe       = 1'b0;
            expAddr     = bus.instr_addr;
        end
        expIAck = nIAck;
        expDAck = nDAck;
    endtask

    task automatic checkStall();
        chk("stall_if", bus.stall_if, bus.instr_req && !expIAck);
        chk("stall_mem", bus.stall_mem, bus.data_req && !expDAck);
    endtask

    task automatic checkOutput();
        chk("mem_req", bus.mem_req, expMemReq);
        chk("mem_we", bus.mem_we, expWe);
        chk("mem_addr", bus.mem_addr, expAddr);
        chk("mem_wdata", bus.mem_wdata, expWdata);
        chk("instr_ack", bus.instr_ack, expIAck);
        chk("data_ack", bus.data_ack, expDAck);
        chk("instr_rdata", bus.instr_rdata, expIRdata);
        chk("data_rdata", bus.data_rdata, expDRdata);
        if (expDAck && dataIsLoad) chk("load_vs_memory", bus.data_rdata, memRead(dataAddr));
    endtask

    // Called at a falling edge: drive inputs, check stalls, step through one rising edge.
    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dwe, input logic [31:0] da,
                                 input logic [31:0] dwd, input logic rdy);
        bus.instr_req  = ir;
        bus.instr_addr = ia;
        bus.data_req   = dr;
        bus.data_we    = dwe;
        bus.data_addr  = da;
        bus.data_wdata = dwd;
        bus.mem_ready  = rdy;
        bus.mem_rdata  = (expMemReq && !expWe) ? memRead(expAddr) : $urandom;
        #1 checkStall();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.instr_req = 1'b0;
        bus.data_req  = 1'b0;
        bus.mem_ready = 1'b0;
        #1 modelReset();
        checkOutput();
        checkStall();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic randomCycle();
        logic rdy;
        if (iActive && expIAck) iActive = 1'b0;
        if (dActive && expDAck) dActive = 1'b0;
        if (!iActive && $urandom_range(0, 3) == 0) begin
            iActive = 1'b1;
            iAddrR  = 32'($urandom_range(0, 15)) << 2;
        end
        if (!dActive && $urandom_range(0, 2) == 0) begin
            dActive = 1'b1;
            dWeR    = 1'($urandom_range(0, 1));
            dAddrR  = 32'($urandom_range(0, 15)) << 2;
            dWdataR = $urandom;
        end
        rdy = expMemReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
        applyStimulus(iActive, iAddrR, dActive, dWeR, dAddrR, dWdataR, rdy);
    endtask

    initial begin
        bus.instr_req  = 1'b0;
        bus.instr_addr = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        iActive = 1'b0; dActive = 1'b0; dWeR = 1'b0;
        iAddrR = '0; dAddrR = '0; dWdataR = '0;
        modelReset();
        memArr[32'h40]  = 32'h8C220004;
        memArr[32'h200] = 32'h12345678;

        @(negedge clk);
        doReset();

        $display("[TB] single fetch, three-cycle memory");
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 1);
        chk("fetch_rdata", bus.instr_rdata, 32'h8C220004);
        applyStimulus(0, 32'h40, 0, 0, 0, 0, 0);

        $display("[TB] single store, immediate memory");
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0);
        chk("store_wdata", bus.mem_wdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] held ack data");
        applyStimulus(0, 0, 1, 0, 32'h200, 0, 0);
        applyStimulus(0, 0, 1, 0, 32'h200, 0, 1);
        chk("load_rdata", bus.data_rdata, 32'h12345678);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 1);
        chk("load_rdata_held", bus.data_rdata, 32'h12345678);
        chk("fetch_after_store", bus.instr_rdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] simultaneous requests, one-cycle memory");
        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(1, 32'h44, 1, 0, 32'h200, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] stray ready while idle");
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        $display("[TB] reset during a data access");
        applyStimulus(0, 0, 1, 1, 32'h300, 32'hCAFEF00D, 0);
        applyStimulus(0, 0, 1, 1, 32'h300, 32'hCAFEF00D, 0);
        rst = 1'b1;
        #1 modelReset();
        checkOutput();
        bus.data_req = 1'b0;
        #1 checkStall();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h48, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h4C, 1, 0, 32'h300, 0, 0);
        chk("post_reset_tie_to_data", bus.mem_addr, 32'h300);
        applyStimulus(1, 32'h4C, 1, 0, 32'h300, 0, 1);
        chk("abandoned_store", bus.data_rdata, 32'h0);

        $display("[TB] randomized traffic");
        doReset();
        for (int i = 0; i < 2000; i++) randomCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
